id_inst_queue: RTL and testbench
================================

// Module: id_inst_queue
// PURPOSE
// Parametrised instruction buffer between IF and ID. It generalises the
// fixed 2-lane a/b decode hand-off to FETCH_W enqueue lanes and ISSUE_W
// dequeue lanes.
// Holds fetched packets (pc, inst, prediction, IF exception) in a circular
// buffer. It presents the oldest ISSUE_W entries to the ISSUE_W decoders.
// Downstream returns a per-cycle consume count, the same meaning as the ID
// consume count: 0..ISSUE_W, oldest-first.
// PARAMETERS
// FETCH_W   2   enqueue lanes per cycle, >=1
// ISSUE_W   2   dequeue/decode lanes per cycle, >=1
// DEPTH     8   entries; power of 2, >= FETCH_W+ISSUE_W
// PORTS
// clk            in   1                 clock
// resetn         in   1                 synchronous, active-low reset
// flush          in   1                 drop all entries (branch mispredict/exception)
// in_valid       in   FETCH_W           per-lane valid; contiguous from lane 0
// in_pc          in   FETCH_W*32        lane i at [32*i+:32]
// in_inst        in   FETCH_W*32        instruction words
// in_pred_taken  in   FETCH_W           predicted taken
// in_pred_target in   FETCH_W*32        predicted target
// in_have_exc    in   FETCH_W           IF-stage exception present
// in_exc_type    in   FETCH_W*$bits(exception_t)  IF exception code
// in_ready       out  1                 free entries >= FETCH_W
// out_valid      out  ISSUE_W           lane i holds the (i+1)-th oldest entry
// out_pc/out_inst/out_pred_taken/out_pred_target/out_have_exc/out_exc_type
//                out  ISSUE_W*(same per-lane widths as inputs)
// consume        in   $clog2(ISSUE_W+1) entries retired from head this cycle
// count          out  $clog2(DEPTH+1)   current occupancy
// consume_err    out  1                 sticky: consume > count was seen
// BEHAVIOUR
// - Reset (resetn=0 at posedge): head=tail=0, count=0, out_valid=0,
//   consume_err=0, in_ready=1. Payload storage is not reset.
// - Enqueue: fires when in_ready && in_valid[0].
//   - n_enq = popcount(in_valid); lanes are written at tail..tail+n_enq-1 mod DEPTH.
//   - Lane 0 is the oldest.
//   - A non-contiguous in_valid is illegal. A simulation assertion flags it.
// - in_ready = (DEPTH - count) >= FETCH_W, using the current count only.
//   - Same-cycle dequeue is not credited. This is conservative and there is
//     no comb path from consume.
// - Dequeue: n_deq = min(consume, count); head advances by n_deq mod DEPTH.
//   - If consume > count, consume_err sets and holds until reset.
// - Outputs are combinational from registered state.
//   - out_valid[i] = (count > i); lane i = entry[(head+i) mod DEPTH].
//   - Payload on invalid lanes is don't-care.
// - Latency: an entry written at edge k is visible on out_* after edge k.
//   Enqueue-to-decode is 1 cycle. There is no bypass when empty.
// - count_next = count + n_enq - n_deq. Simultaneous enq+deq is legal at any
//   occupancy, including full and empty.
// - Pointers are $clog2(DEPTH) bits and wrap naturally. A packet may straddle
//   the wrap point (e.g. tail=7, n_enq=2 writes entries 7 and 0).
// - flush=1 at posedge: head=tail=count=0.
//   - Enqueue and dequeue in that cycle are discarded.
//   - consume_err is not evaluated and is not cleared by flush.
//   - in_ready stays as computed from the pre-flush count in that cycle.
// - Reset overrides flush. Reset mid-burst drops everything. The first
//   enqueue after reset is accepted on the first cycle with resetn=1.
// - Invariant: count <= DEPTH at all times. An assertion checks it.
// TESTING (FETCH_W=2, ISSUE_W=2, DEPTH=8)
// 1 reset, in_valid=11 pc=0x1c000000/04, consume=0 -> next cycle
//   out_valid=11, out_pc=0x1c000000/0x1c000004, count=2
// 2 fill 4 packets, consume=0 -> count=8, in_ready=0; in_valid=11 held ->
//   no write, count stays 8; consume=2 -> count=6, in_ready=1 next cycle
// 3 tail=7 head=3 count=4, enq 2, consume=1 -> entries 7 and 0 written,
//   head=4, count=5, out lanes = entries 4,5 in order
// 4 count=1, consume=2 -> count=0, consume_err=1 and stays 1 after flush
// 5 count=5, flush=1 with in_valid=11 and consume=2 -> count=0,
//   out_valid=00; next packet lands at entry 0
// 6 resetn=0 asserted with count=6 mid-stream -> count=0, out_valid=00,
//   consume_err=0 next cycle

Source files
------------

// File: rtl/id_inst_queue.sv
// id_inst_queue: instruction buffer between IF and ID.
//
// Circular buffer of fetched packets (pc, inst, branch prediction, IF
// exception). Up to FETCH_W packets are enqueued per cycle, oldest in lane 0.
// The oldest ISSUE_W entries are presented to the decoders. Downstream
// retires 0..ISSUE_W of them per cycle, oldest first, through `consume`.
//
// Ports
//   clk, resetn      clock, synchronous active-low reset
//   flush            drop every entry (mispredict / exception redirect)
//   in_*             FETCH_W enqueue lanes; lane i at [W*i +: W]
//   in_ready         at least FETCH_W entries are free (current count only)
//   out_*            ISSUE_W dequeue lanes; lane i = (i+1)-th oldest entry
//   consume          number of entries retired from the head this cycle
//   count            current occupancy
//   consume_err      sticky: a consume larger than count was seen

package id_inst_queue_pkg;
  typedef logic [5:0] exception_t;
endpackage

module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                flush,
  input  logic [FETCH_W-1:0]                  in_valid,
  input  logic [FETCH_W*32-1:0]               in_pc,
  input  logic [FETCH_W*32-1:0]               in_inst,
  input  logic [FETCH_W-1:0]                  in_pred_taken,
  input  logic [FETCH_W*32-1:0]               in_pred_target,
  input  logic [FETCH_W-1:0]                  in_have_exc,
  input  logic [FETCH_W*$bits(exception_t)-1:0] in_exc_type,
  output logic                                in_ready,
  output logic [ISSUE_W-1:0]                  out_valid,
  output logic [ISSUE_W*32-1:0]               out_pc,
  output logic [ISSUE_W*32-1:0]               out_inst,
  output logic [ISSUE_W-1:0]                  out_pred_taken,
  output logic [ISSUE_W*32-1:0]               out_pred_target,
  output logic [ISSUE_W-1:0]                  out_have_exc,
  output logic [ISSUE_W*$bits(exception_t)-1:0] out_exc_type,
  input  logic [$clog2(ISSUE_W+1)-1:0]        consume,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic                                consume_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int EXC_W = $bits(exception_t);

  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      inst_q   [DEPTH];
  logic             taken_q  [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic             exc_q    [DEPTH];
  exception_t       etype_q  [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             consume_err_q;

  logic [CNT_W-1:0] n_enq_raw;
  logic [CNT_W-1:0] n_enq;
  logic [CNT_W-1:0] n_deq;
  logic [CNT_W-1:0] consume_ext;
  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] count_next;
  logic             enq_fire;
  logic             over_consume;
  logic [PTR_W-1:0] wr_idx [FETCH_W];
  logic [PTR_W-1:0] rd_idx [ISSUE_W];

  assign count       = count_q;
  assign consume_err = consume_err_q;

  // Lanes are contiguous from lane 0, so the popcount is the packet length.
  always_comb begin
    n_enq_raw = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (in_valid[i]) n_enq_raw = n_enq_raw + CNT_W'(1);
    end
  end

  // in_ready looks at the current count only: same-cycle dequeue is not
  // credited, which keeps consume off the in_ready timing path.
  assign free_cnt     = CNT_W'(DEPTH) - count_q;
  assign in_ready     = free_cnt >= CNT_W'(FETCH_W);
  assign enq_fire     = in_ready && in_valid[0];
  assign n_enq        = enq_fire ? n_enq_raw : '0;

  assign consume_ext  = CNT_W'(consume);
  assign over_consume = consume_ext > count_q;
  assign n_deq        = over_consume ? count_q : consume_ext;
  assign count_next   = count_q + n_enq - n_deq;

  // Pointers are log2(DEPTH) wide, so the adds wrap modulo DEPTH and a
  // packet may straddle the wrap point.
  always_comb begin
    for (int i = 0; i < FETCH_W; i++) wr_idx[i] = tail_q + PTR_W'(i);
    for (int i = 0; i < ISSUE_W; i++) rd_idx[i] = head_q + PTR_W'(i);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      consume_err_q <= 1'b0;
    end else if (flush) begin
      // consume_err is neither evaluated nor cleared on a flush cycle.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + n_deq[PTR_W-1:0];
      tail_q  <= tail_q + n_enq[PTR_W-1:0];
      count_q <= count_next;
      if (over_consume) consume_err_q <= 1'b1;
    end
  end

  // Payload storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (resetn && !flush && enq_fire) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (in_valid[i]) begin
          pc_q[wr_idx[i]]     <= in_pc[32*i +: 32];
          inst_q[wr_idx[i]]   <= in_inst[32*i +: 32];
          taken_q[wr_idx[i]]  <= in_pred_taken[i];
          target_q[wr_idx[i]] <= in_pred_target[32*i +: 32];
          exc_q[wr_idx[i]]    <= in_have_exc[i];
          etype_q[wr_idx[i]]  <= in_exc_type[EXC_W*i +: EXC_W];
        end
      end
    end
  end

  always_comb begin
    out_valid       = '0;
    out_pc          = '0;
    out_inst        = '0;
    out_pred_taken  = '0;
    out_pred_target = '0;
    out_have_exc    = '0;
    out_exc_type    = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      out_valid[i]                 = count_q > CNT_W'(i);
      out_pc[32*i +: 32]           = pc_q[rd_idx[i]];
      out_inst[32*i +: 32]         = inst_q[rd_idx[i]];
      out_pred_taken[i]            = taken_q[rd_idx[i]];
      out_pred_target[32*i +: 32]  = target_q[rd_idx[i]];
      out_have_exc[i]              = exc_q[rd_idx[i]];
      out_exc_type[EXC_W*i +: EXC_W] = etype_q[rd_idx[i]];
    end
  end

  // A valid pattern like 2'b10 leaves a hole in the packet.
  a_in_valid_contig: assert property (@(posedge clk) disable iff (!resetn)
    ((in_valid & (in_valid + FETCH_W'(1))) == '0));

  a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
    (count_q <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_id_inst_queue.sv
module tb_id_inst_queue;
  import id_inst_queue_pkg::*;

  localparam int EW = $bits(exception_t);

  logic          clk;
  logic          resetn;
  logic          flush;
  logic [1:0]    in_valid;
  logic [63:0]   in_pc;
  logic [63:0]   in_inst;
  logic [1:0]    in_pred_taken;
  logic [63:0]   in_pred_target;
  logic [1:0]    in_have_exc;
  logic [2*EW-1:0] in_exc_type;
  logic          in_ready;
  logic [1:0]    out_valid;
  logic [63:0]   out_pc;
  logic [63:0]   out_inst;
  logic [1:0]    out_pred_taken;
  logic [63:0]   out_pred_target;
  logic [1:0]    out_have_exc;
  logic [2*EW-1:0] out_exc_type;
  logic [1:0]    consume;
  logic [3:0]    count;
  logic          consume_err;

  int n_pass  = 0;
  int n_total = 0;

  id_inst_queue #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_pc           (in_pc),
    .in_inst         (in_inst),
    .in_pred_taken   (in_pred_taken),
    .in_pred_target  (in_pred_target),
    .in_have_exc     (in_have_exc),
    .in_exc_type     (in_exc_type),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_pred_taken  (out_pred_taken),
    .out_pred_target (out_pred_target),
    .out_have_exc    (out_have_exc),
    .out_exc_type    (out_exc_type),
    .consume         (consume),
    .count           (count),
    .consume_err     (consume_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload fields are derived from the pc so every lane carries distinct data.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] tgt_of(input logic [31:0] pc);
    return pc + 32'h100;
  endfunction
  function automatic exception_t etype_of(input logic [31:0] pc);
    return exception_t'(pc[7:2]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    in_valid       = v;
    in_pc          = {pc1, pc0};
    in_inst        = {inst_of(pc1), inst_of(pc0)};
    in_pred_taken  = {pc1[2], pc0[2]};
    in_pred_target = {tgt_of(pc1), tgt_of(pc0)};
    in_have_exc    = {pc1[3], pc0[3]};
    in_exc_type    = {etype_of(pc1), etype_of(pc0)};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] v,
                         input logic [31:0] pc0, input logic [31:0] pc1);
    logic [31:0] pcs [2];
    pcs[0] = pc0;
    pcs[1] = pc1;
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    for (int i = 0; i < 2; i++) begin
      if (v[i]) begin
        chk($sformatf("%s_pc%0d", tag, i),    64'(out_pc[32*i +: 32]),          64'(pcs[i]));
        chk($sformatf("%s_inst%0d", tag, i),  64'(out_inst[32*i +: 32]),        64'(inst_of(pcs[i])));
        chk($sformatf("%s_taken%0d", tag, i), 64'(out_pred_taken[i]),           64'(pcs[i][2]));
        chk($sformatf("%s_tgt%0d", tag, i),   64'(out_pred_target[32*i +: 32]), 64'(tgt_of(pcs[i])));
        chk($sformatf("%s_exc%0d", tag, i),   64'(out_have_exc[i]),             64'(pcs[i][3]));
        chk($sformatf("%s_etype%0d", tag, i), 64'(out_exc_type[EW*i +: EW]),    64'(etype_of(pcs[i])));
      end
    end
  endtask

  localparam logic [31:0] P = 32'h1c00_0100;
  localparam logic [31:0] Q = 32'h1c00_0200;
  localparam logic [31:0] R = 32'h1c00_0300;
  localparam logic [31:0] S = 32'h1c00_0400;

  initial begin
    resetn  = 1'b0;
    flush   = 1'b0;
    consume = 2'd0;
    drive(2'b00, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_err", 64'(consume_err), 64'd0);

    // 1: first packet after reset is visible one edge later
    resetn = 1'b1;
    drive(2'b11, 32'h1c00_0000, 32'h1c00_0004);
    tick();
    chk_out("t1", 2'b11, 32'h1c00_0000, 32'h1c00_0004);
    chk("t1_count", 64'(count), 64'd2);

    // 2: fill to full, hold while full, then drain two
    drive(2'b11, 32'h1c00_0008, 32'h1c00_000c);
    tick();
    chk("t2_count4", 64'(count), 64'd4);
    drive(2'b11, 32'h1c00_0010, 32'h1c00_0014);
    tick();
    chk("t2_count6", 64'(count), 64'd6);
    chk("t2_ready6", 64'(in_ready), 64'd1);
    drive(2'b11, 32'h1c00_0018, 32'h1c00_001c);
    tick();
    chk("t2_count8", 64'(count), 64'd8);
    chk("t2_ready8", 64'(in_ready), 64'd0);
    drive(2'b11, 32'h1c00_0020, 32'h1c00_0024);
    tick();
    chk("t2_hold_count", 64'(count), 64'd8);
    chk("t2_hold_ready", 64'(in_ready), 64'd0);
    chk_out("t2_hold", 2'b11, 32'h1c00_0000, 32'h1c00_0004);
    consume = 2'd2;
    tick();
    chk("t2_drain_count", 64'(count), 64'd6);
    chk("t2_drain_ready", 64'(in_ready), 64'd1);
    chk_out("t2_drain", 2'b11, 32'h1c00_0008, 32'h1c00_000c);

    // 3: reach head=3 tail=7 count=4, then a packet straddling the wrap
    drive(2'b00, 32'h0, 32'h0);
    consume = 2'd0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_flush_count", 64'(count), 64'd0);
    drive(2'b11, P + 0, P + 4);
    tick();
    drive(2'b11, P + 8, P + 12);
    tick();
    drive(2'b11, P + 16, P + 20);
    consume = 2'd2;
    tick();
    chk("t3_c_count", 64'(count), 64'd4);
    drive(2'b01, P + 24, 32'h0);
    consume = 2'd1;
    tick();
    chk("t3_pre_count", 64'(count), 64'd4);
    chk_out("t3_pre", 2'b11, P + 12, P + 16);
    drive(2'b11, P + 28, P + 32);
    consume = 2'd1;
    tick();
    chk("t3_wrap_count", 64'(count), 64'd5);
    chk_out("t3_wrap", 2'b11, P + 16, P + 20);
    drive(2'b00, 32'h0, 32'h0);
    consume = 2'd2;
    tick();
    chk("t3_d1_count", 64'(count), 64'd3);
    chk_out("t3_d1", 2'b11, P + 24, P + 28);
    tick();
    chk("t3_d2_count", 64'(count), 64'd1);
    chk_out("t3_d2", 2'b01, P + 32, 32'h0);
    chk("t3_err", 64'(consume_err), 64'd0);

    // 4: over-consume sets the sticky error, flush does not clear it
    consume = 2'd2;
    tick();
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_err", 64'(consume_err), 64'd1);
    chk("t4_valid", 64'(out_valid), 64'd0);
    consume = 2'd0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_err", 64'(consume_err), 64'd1);
    tick();
    chk("t4_hold_err", 64'(consume_err), 64'd1);

    // 5: flush with concurrent enqueue and consume discards both
    drive(2'b11, Q + 0, Q + 4);
    tick();
    drive(2'b11, Q + 8, Q + 12);
    tick();
    drive(2'b01, Q + 16, 32'h0);
    tick();
    chk("t5_count5", 64'(count), 64'd5);
    chk("t5_ready5", 64'(in_ready), 64'd1);
    drive(2'b11, Q + 20, Q + 24);
    consume = 2'd2;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    consume = 2'd0;
    drive(2'b00, 32'h0, 32'h0);
    chk("t5_flush_count", 64'(count), 64'd0);
    chk("t5_flush_valid", 64'(out_valid), 64'd0);
    chk("t5_flush_ready", 64'(in_ready), 64'd1);
    drive(2'b11, R + 0, R + 4);
    tick();
    chk("t5_next_count", 64'(count), 64'd2);
    chk_out("t5_next", 2'b11, R + 0, R + 4);

    // 6: reset mid-stream drops everything and clears the sticky error
    drive(2'b11, R + 8, R + 12);
    tick();
    drive(2'b11, R + 16, R + 20);
    tick();
    chk("t6_count6", 64'(count), 64'd6);
    chk("t6_err_pre", 64'(consume_err), 64'd1);
    resetn = 1'b0;
    drive(2'b11, R + 24, R + 28);
    consume = 2'd1;
    tick();
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_err", 64'(consume_err), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd1);
    resetn  = 1'b1;
    consume = 2'd0;
    drive(2'b11, S + 0, S + 4);
    tick();
    chk("t6_first_count", 64'(count), 64'd2);
    chk_out("t6_first", 2'b11, S + 0, S + 4);
    drive(2'b00, 32'h0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
